// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and the sync/pixel pipeline payload.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned CNT_W = 10;

  // Per-pixel attributes travelling alongside the BRAM read
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic visible;
    logic in_image;
    logic frame_start;
    logic de;
  } pipe_t;

  localparam pipe_t PIPE_IDLE = '{hsync: 1'b1, vsync: 1'b1, visible: 1'b0,
                                  in_image: 1'b0, frame_start: 1'b0, de: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with raw (undelayed) sync and visible flags.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_ACTIVE,
  parameter int unsigned V_VISIBLE = V_ACTIVE
) (
  input  logic             clock,
  input  logic             reset,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             hsync_raw_c,
  output logic             vsync_raw_c,
  output logic             visible_c
);

  localparam int unsigned H_LAST   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1;
  localparam int unsigned V_LAST   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;

  always_comb begin
    hc_d = hc_q + CNT_W'(1);
    vc_d = vc_q;
    if (hc_q == CNT_W'(H_LAST)) begin
      hc_d = '0;
      vc_d = (vc_q == CNT_W'(V_LAST)) ? '0 : vc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  always_comb begin
    hc          = hc_q;
    vc          = vc_q;
    hsync_raw_c = !((hc_q >= CNT_W'(HS_START)) && (hc_q < CNT_W'(HS_END)));
    vsync_raw_c = !((vc_q >= CNT_W'(VS_START)) && (vc_q < CNT_W'(VS_END)));
    visible_c   = (hc_q < CNT_W'(H_VISIBLE)) && (vc_q < CNT_W'(V_VISIBLE));
  end

endmodule

// File: rtl/vga_frame_reader.sv
// Scans a stored image out of a 1-cycle-latency BRAM into a centred VGA window,
// delaying syncs and flags two cycles so they line up with the pixel data.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE     = 640,
  parameter int unsigned V_VISIBLE     = 480,
  parameter int unsigned IMG_WIDTH     = 160,
  parameter int unsigned IMG_HEIGHT    = 120,
  parameter int unsigned IMG_X0        = 240,
  parameter int unsigned IMG_Y0        = 180,
  parameter int unsigned RAM_ADDR_BITS = 15,
  parameter int unsigned PIXEL_BITS    = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     display_enable,
  output logic                     ram_enable,
  output logic [RAM_ADDR_BITS-1:0] address,
  input  logic [PIXEL_BITS-1:0]    ram_data,
  output logic                     hsync,
  output logic                     vsync,
  output logic [PIXEL_BITS-1:0]    rgb,
  output logic                     frame_start
);

  localparam int unsigned X_END = IMG_X0 + IMG_WIDTH;
  localparam int unsigned Y_END = IMG_Y0 + IMG_HEIGHT;

  logic [CNT_W-1:0] hc, vc;
  logic             hsync_raw_c, vsync_raw_c, visible_c;
  logic             in_image_c, origin_c;

  vga_timing #(
    .H_VISIBLE(H_VISIBLE),
    .V_VISIBLE(V_VISIBLE)
  ) u_timing (
    .clock      (clock),
    .reset      (reset),
    .hc         (hc),
    .vc         (vc),
    .hsync_raw_c(hsync_raw_c),
    .vsync_raw_c(vsync_raw_c),
    .visible_c  (visible_c)
  );

  always_comb begin
    in_image_c = (hc >= CNT_W'(IMG_X0)) && (hc < CNT_W'(X_END)) &&
                 (vc >= CNT_W'(IMG_Y0)) && (vc < CNT_W'(Y_END));
    origin_c   = (hc == '0) && (vc == '0);
    ram_enable = in_image_c && !reset;
  end

  // Linear read pointer: raster order inside the window equals storage order
  logic [RAM_ADDR_BITS-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (origin_c) begin
      ptr_d = '0;
    end else if (in_image_c) begin
      ptr_d = ptr_q + RAM_ADDR_BITS'(1);
    end
  end

  assign address = ptr_q;

  // Stage 1 aligns with ram_data, stage 2 is the output register
  pipe_t                 s1_q, s1_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  frame_start_q, frame_start_d;
  logic [PIXEL_BITS-1:0] rgb_q, rgb_d;

  always_comb begin
    s1_d             = PIPE_IDLE;
    s1_d.hsync       = hsync_raw_c;
    s1_d.vsync       = vsync_raw_c;
    s1_d.visible     = visible_c;
    s1_d.in_image    = in_image_c;
    s1_d.frame_start = origin_c;
    s1_d.de          = display_enable;

    hsync_d       = s1_q.hsync;
    vsync_d       = s1_q.vsync;
    frame_start_d = s1_q.frame_start;
    rgb_d         = '0;
    if (s1_q.visible && s1_q.in_image && s1_q.de) begin
      rgb_d = ram_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q         <= '0;
      s1_q          <= PIPE_IDLE;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      ptr_q         <= ptr_d;
      s1_q          <= s1_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: timing, window edges, pointer, blanking, reset.
module tb_vga_frame_reader;

  localparam int FRAME = 420000;
  localparam int LINE  = 800;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        display_enable = 1'b1;
  logic        ram_enable;
  logic [14:0] address;
  logic [11:0] ram_data = '0;
  logic        hsync, vsync, frame_start;
  logic [11:0] rgb;

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;

  vga_frame_reader dut (
    .clock         (clock),
    .reset         (reset),
    .display_enable(display_enable),
    .ram_enable    (ram_enable),
    .address       (address),
    .ram_data      (ram_data),
    .hsync         (hsync),
    .vsync         (vsync),
    .rgb           (rgb),
    .frame_start   (frame_start)
  );

  always #5 clock = ~clock;

  // Raster position model: cycles since the counters were last at (0,0)
  always @(posedge clock) pos <= reset ? 0 : pos + 1;

  // BRAM model preloaded with data[i] = i[11:0]
  always @(posedge clock) if (ram_enable) ram_data <= address[11:0];

  int   hfall[$], hrise[$], vfall[$], vrise[$], fsrise[$];
  int   en_cnt[2]     = '{0, 0};
  int   first_addr[2] = '{-1, -1};
  int   fs_hi0 = 0;
  logic hs_p = 1'b1, vs_p = 1'b1, fs_p = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      if (hs_p && !hsync) hfall.push_back(pos);
      if (!hs_p && hsync) hrise.push_back(pos);
      if (vs_p && !vsync) vfall.push_back(pos);
      if (!vs_p && vsync) vrise.push_back(pos);
      if (frame_start && !fs_p) fsrise.push_back(pos);
      if (frame_start && pos < FRAME) fs_hi0 <= fs_hi0 + 1;
      if (ram_enable && pos < 2 * FRAME) begin
        if (en_cnt[pos / FRAME] == 0) first_addr[pos / FRAME] <= int'(address);
        en_cnt[pos / FRAME] <= en_cnt[pos / FRAME] + 1;
      end
      hs_p <= hsync;
      vs_p <= vsync;
      fs_p <= frame_start;
    end
  end

  task automatic wait_pos(input int p);
    for (int i = 0; i < 600000 && pos != p; i++) @(negedge clock);
    if (pos != p) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_pos: reached pos %0d, required %0d", pos, p);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    n_checks++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL rst_hsync: got %b required 1", hsync); end
    n_checks++; if (vsync !== 1'b1) begin n_fail++; $display("FAIL rst_vsync: got %b required 1", vsync); end
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL rst_rgb: got %h required 000", rgb); end
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_fs: got %b required 0", frame_start); end
    n_checks++; if (ram_enable !== 1'b0) begin n_fail++; $display("FAIL rst_ram_en: got %b required 0", ram_enable); end
    n_checks++; if (address !== 15'd0) begin n_fail++; $display("FAIL rst_addr: got %0d required 0", address); end
    reset = 1'b0;
    wait_pos(1);
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL fs_pos1: got %b required 0", frame_start); end
    wait_pos(2);
    n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL fs_pos2: got %b required 1", frame_start); end
    n_checks++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL hsync_pos2: got %b required 1", hsync); end
    wait_pos(3);
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL fs_pos3: got %b required 0", frame_start); end
  endtask

  task automatic test_pixels;
    wait_pos(179 * LINE + 300);
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL border_top: got %h required 000", rgb); end
    wait_pos(180 * LINE + 240);
    n_checks++; if (ram_enable !== 1'b1) begin n_fail++; $display("FAIL first_en: got %b required 1", ram_enable); end
    n_checks++; if (address !== 15'd0) begin n_fail++; $display("FAIL first_addr: got %0d required 0", address); end
    wait_pos(180 * LINE + 241);
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL edge_left: got %h required 000", rgb); end
    wait_pos(180 * LINE + 242);
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL pix_0: got %h required 000", rgb); end
    wait_pos(180 * LINE + 243);
    n_checks++; if (rgb !== 12'h001) begin n_fail++; $display("FAIL pix_1: got %h required 001", rgb); end
    wait_pos(180 * LINE + 401);
    n_checks++; if (rgb !== 12'h09F) begin n_fail++; $display("FAIL pix_159: got %h required 09f", rgb); end
    wait_pos(180 * LINE + 402);
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL edge_right: got %h required 000", rgb); end
    wait_pos(181 * LINE + 242);
    n_checks++; if (rgb !== 12'h0A0) begin n_fail++; $display("FAIL pix_160: got %h required 0a0", rgb); end
    wait_pos(299 * LINE + 399);
    n_checks++; if (address !== 15'd19199) begin n_fail++; $display("FAIL last_addr: got %0d required 19199", address); end
    wait_pos(299 * LINE + 401);
    n_checks++; if (rgb !== 12'hAFF) begin n_fail++; $display("FAIL pix_last: got %h required aff", rgb); end
    wait_pos(299 * LINE + 402);
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL edge_last: got %h required 000", rgb); end
  endtask

  task automatic test_display_enable;
    int b;
    b = FRAME + 200 * LINE;
    wait_pos(b + 300);
    n_checks++; if (rgb !== 12'hCBA) begin n_fail++; $display("FAIL de_before: got %h required cba", rgb); end
    display_enable = 1'b0;
    wait_pos(b + 301);
    n_checks++; if (rgb !== 12'hCBB) begin n_fail++; $display("FAIL de_lat: got %h required cbb", rgb); end
    wait_pos(b + 302);
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL de_blank: got %h required 000", rgb); end
    n_checks++; if (vsync !== 1'b1) begin n_fail++; $display("FAIL de_vsync: got %b required 1", vsync); end
    wait_pos(b + 657);
    n_checks++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL de_hs_pre: got %b required 1", hsync); end
    wait_pos(b + 658);
    n_checks++; if (hsync !== 1'b0) begin n_fail++; $display("FAIL de_hs_low: got %b required 0", hsync); end
    wait_pos(b + 753);
    n_checks++; if (hsync !== 1'b0) begin n_fail++; $display("FAIL de_hs_end: got %b required 0", hsync); end
    wait_pos(b + 754);
    n_checks++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL de_hs_post: got %b required 1", hsync); end
    wait_pos(b + LINE + 300);
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL de_next_line: got %h required 000", rgb); end
    wait_pos(FRAME + 310 * LINE);
    display_enable = 1'b1;
  endtask

  task automatic test_periods;
    wait_pos(2 * FRAME + 10);
    n_checks++; if (hfall.size() < 2 || hfall[0] != 658) begin n_fail++; $display("FAIL hs_first: got %0d entries required first fall 658", hfall.size()); end
    n_checks++; if (hfall.size() < 2 || hfall[1] - hfall[0] != 800) begin n_fail++; $display("FAIL hs_period: required 800"); end
    n_checks++; if (hrise.size() < 1 || hfall.size() < 1 || hrise[0] - hfall[0] != 96) begin n_fail++; $display("FAIL hs_low: required 96"); end
    n_checks++; if (vfall.size() < 1 || vfall[0] != 392002) begin n_fail++; $display("FAIL vs_first: %0d entries required first fall 392002", vfall.size()); end
    n_checks++; if (vfall.size() < 1 || vrise.size() < 1 || vrise[0] - vfall[0] != 1600) begin n_fail++; $display("FAIL vs_low: required 1600"); end
    n_checks++; if (vfall.size() < 2 || vfall[1] - vfall[0] != 420000) begin n_fail++; $display("FAIL vs_period: %0d falls required period 420000", vfall.size()); end
    n_checks++; if (fsrise.size() < 1 || fsrise[0] != 2) begin n_fail++; $display("FAIL fs_first: %0d pulses required first at 2", fsrise.size()); end
    n_checks++; if (fsrise.size() < 2 || fsrise[1] - fsrise[0] != 420000) begin n_fail++; $display("FAIL fs_period: %0d pulses required period 420000", fsrise.size()); end
    n_checks++; if (fs_hi0 != 1) begin n_fail++; $display("FAIL fs_width: got %0d cycles required 1", fs_hi0); end
  endtask

  task automatic test_ram_enable;
    n_checks++; if (en_cnt[0] != 19200) begin n_fail++; $display("FAIL en_cnt0: got %0d required 19200", en_cnt[0]); end
    n_checks++; if (en_cnt[1] != 19200) begin n_fail++; $display("FAIL en_cnt1: got %0d required 19200", en_cnt[1]); end
    n_checks++; if (first_addr[0] != 0) begin n_fail++; $display("FAIL en_addr0: got %0d required 0", first_addr[0]); end
    n_checks++; if (first_addr[1] != 0) begin n_fail++; $display("FAIL en_addr1: got %0d required 0", first_addr[1]); end
  endtask

  task automatic test_reset_midframe;
    wait_pos(2 * FRAME + 250 * LINE + 300);
    n_checks++; if (rgb !== 12'hBFA) begin n_fail++; $display("FAIL mid_pix: got %h required bfa", rgb); end
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL mid_rst_rgb: got %h required 000", rgb); end
    n_checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_fail++; $display("FAIL mid_rst_sync: got %b%b required 11", hsync, vsync); end
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL mid_rst_fs: got %b required 0", frame_start); end
    n_checks++; if (ram_enable !== 1'b0 || address !== 15'd0) begin n_fail++; $display("FAIL mid_rst_ram: got en %b addr %0d required 0 0", ram_enable, address); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL mid_fs0: got %b required 0", frame_start); end
    wait_pos(2);
    n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL mid_fs2: got %b required 1", frame_start); end
    n_checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_fail++; $display("FAIL mid_sync2: got %b%b required 11", hsync, vsync); end
    wait_pos(180 * LINE + 240);
    n_checks++; if (ram_enable !== 1'b1 || address !== 15'd0) begin n_fail++; $display("FAIL mid_addr: got en %b addr %0d required 1 0", ram_enable, address); end
    wait_pos(180 * LINE + 242);
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL mid_pix0: got %h required 000", rgb); end
    wait_pos(180 * LINE + 243);
    n_checks++; if (rgb !== 12'h001) begin n_fail++; $display("FAIL mid_pix1: got %h required 001", rgb); end
  endtask

  initial begin
    test_reset();
    test_pixels();
    test_display_enable();
    test_periods();
    test_ram_enable();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #30000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
